// File: rtl/fracnet_udiv_seq_if.sv
// Handshake and operand/result bundle for the sequential unsigned divider.
// master: the producer that issues divisions. slave: the divider itself.
interface fracnet_udiv_seq_if #(
    parameter int DIVIDEND_WIDTH = 18,
    parameter int DIVISOR_WIDTH  = 5
);
    logic                      ce;
    logic                      start;
    logic [DIVIDEND_WIDTH-1:0] dividend;
    logic [DIVISOR_WIDTH-1:0]  divisor;
    logic                      ready;
    logic                      done;
    logic [DIVIDEND_WIDTH-1:0] quotient;
    logic [DIVISOR_WIDTH-1:0]  remainder;
    logic                      div_by_zero;

    modport master (
        output ce, start, dividend, divisor,
        input  ready, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  ce, start, dividend, divisor,
        output ready, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/fracnet_udiv_seq.sv
// Radix-2 restoring unsigned divider, one quotient bit per ce-qualified cycle.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | ready=1; waiting for start, last result held on the outputs
// CALC  | iterating; one restoring step per ce=1 edge, cnt counts down
module fracnet_udiv_seq #(
    parameter int DIVIDEND_WIDTH = 18,
    parameter int DIVISOR_WIDTH  = 5
) (
    input  logic               clk,
    input  logic               reset,
    fracnet_udiv_seq_if.slave  bus
);
    localparam int DW = DIVIDEND_WIDTH;
    localparam int VW = DIVISOR_WIDTH;
    localparam int CW = $clog2(DW + 1);

    typedef enum logic {
        IDLE = 1'b0,
        CALC = 1'b1
    } state_t;

    state_t        state;
    logic [DW-1:0] shift_q;
    logic [VW-1:0] dvs_q;
    logic [VW:0]   rem_q;
    logic [CW-1:0] cnt;
    logic          ready_q;
    logic          done_q;
    logic [DW-1:0] quot_q;
    logic [VW-1:0] rmd_q;
    logic          dbz_q;

    // One restoring step: shift the next dividend bit into the partial
    // remainder and subtract the divisor when it fits. The partial remainder
    // is one bit wider than the divisor so the compare cannot overflow.
    logic [VW:0]   rem_shift;
    logic          fits;
    logic [VW:0]   rem_next;
    logic [DW-1:0] shift_next;
    logic          dvs_zero;

    always_comb begin
        rem_shift  = {rem_q[VW-1:0], shift_q[DW-1]};
        fits       = (rem_shift >= {1'b0, dvs_q});
        rem_next   = fits ? (rem_shift - {1'b0, dvs_q}) : rem_shift;
        shift_next = {shift_q[DW-2:0], fits};
        dvs_zero   = (dvs_q == '0);
    end

    // Control FSM and datapath registers; ce=0 freezes everything.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            shift_q <= '0;
            dvs_q   <= '0;
            rem_q   <= '0;
            cnt     <= '0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
            quot_q  <= '0;
            rmd_q   <= '0;
            dbz_q   <= 1'b0;
        end else if (bus.ce) begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        shift_q <= bus.dividend;
                        dvs_q   <= bus.divisor;
                        rem_q   <= '0;
                        cnt     <= CW'(DW);
                        ready_q <= 1'b0;
                        state   <= CALC;
                    end
                end
                CALC: begin
                    shift_q <= shift_next;
                    rem_q   <= rem_next;
                    cnt     <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        // A zero divisor runs the full sequence; its result
                        // is forced to the saturated quotient and zero remainder.
                        quot_q  <= dvs_zero ? '1 : shift_next;
                        rmd_q   <= dvs_zero ? '0 : rem_next[VW-1:0];
                        dbz_q   <= dvs_zero;
                        done_q  <= 1'b1;
                        ready_q <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.ready       = ready_q;
    assign bus.done        = done_q;
    assign bus.quotient    = quot_q;
    assign bus.remainder   = rmd_q;
    assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_fracnet_udiv_seq.sv
// Directed bench for the sequential unsigned divider: a vector table run
// back-to-back, plus hand-written stall, ignored-start and reset sequences.
module tb_fracnet_udiv_seq;
    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    fracnet_udiv_seq_if #(.DIVIDEND_WIDTH(18), .DIVISOR_WIDTH(5)) bus ();

    fracnet_udiv_seq #(.DIVIDEND_WIDTH(18), .DIVISOR_WIDTH(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [17:0] a;
        logic [4:0]  b;
        logic [17:0] q;
        logic [4:0]  r;
        logic        z;
    } vec_t;

    vec_t vecs [9];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    // Issue one division and wait for done. lat = edges after the accepting edge.
    task automatic run_div(input logic [17:0] a, input logic [4:0] b,
                           output int lat, output bit rdy_ok);
        bus.dividend = a;
        bus.divisor  = b;
        bus.start    = 1'b1;
        step();
        bus.start = 1'b0;
        chk("done_clear_on_accept", bus.done, 0);
        rdy_ok = (bus.ready === 1'b0);
        lat = -1;
        for (int i = 1; i <= 60; i++) begin
            step();
            if (bus.done === 1'b1) begin
                lat = i;
                break;
            end
            if (bus.ready !== 1'b0) rdy_ok = 1'b0;
        end
    endtask

    initial begin
        int lat;
        bit rdy_ok;
        int t1;
        int edges;
        int extra_done;
        bit hold_ok;

        vecs[0] = '{a: 18'd100,    b: 5'd7,  q: 18'd14,     r: 5'd2,  z: 1'b0};
        vecs[1] = '{a: 18'd262143, b: 5'd31, q: 18'd8456,   r: 5'd7,  z: 1'b0};
        vecs[2] = '{a: 18'd3,      b: 5'd17, q: 18'd0,      r: 5'd3,  z: 1'b0};
        vecs[3] = '{a: 18'd31,     b: 5'd1,  q: 18'd31,     r: 5'd0,  z: 1'b0};
        vecs[4] = '{a: 18'd1234,   b: 5'd0,  q: 18'h3FFFF,  r: 5'd0,  z: 1'b1};
        vecs[5] = '{a: 18'd50,     b: 5'd5,  q: 18'd10,     r: 5'd0,  z: 1'b0};
        vecs[6] = '{a: 18'd65535,  b: 5'd31, q: 18'd2114,   r: 5'd1,  z: 1'b0};
        vecs[7] = '{a: 18'd1000,   b: 5'd30, q: 18'd33,     r: 5'd10, z: 1'b0};
        vecs[8] = '{a: 18'd0,      b: 5'd9,  q: 18'd0,      r: 5'd0,  z: 1'b0};

        reset        = 1'b1;
        bus.ce       = 1'b1;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        step();
        step();
        chk("rst_ready", bus.ready, 1);
        chk("rst_done", bus.done, 0);
        chk("rst_quotient", bus.quotient, 0);
        chk("rst_remainder", bus.remainder, 0);
        chk("rst_dbz", bus.div_by_zero, 0);
        reset = 1'b0;
        step();

        // Table vectors, each started while the previous done is high.
        for (int i = 0; i < 9; i++) begin
            run_div(vecs[i].a, vecs[i].b, lat, rdy_ok);
            chk($sformatf("v%0d_latency", i), lat, 18);
            chk($sformatf("v%0d_ready_low", i), rdy_ok, 1);
            chk($sformatf("v%0d_ready_at_done", i), bus.ready, 1);
            chk($sformatf("v%0d_quotient", i), bus.quotient, vecs[i].q);
            chk($sformatf("v%0d_remainder", i), bus.remainder, vecs[i].r);
            chk($sformatf("v%0d_dbz", i), bus.div_by_zero, vecs[i].z);
        end

        // Done-to-done spacing for back-to-back issue.
        run_div(18'd3, 5'd17, lat, rdy_ok);
        t1 = cyc;
        run_div(18'd31, 5'd1, lat, rdy_ok);
        chk("b2b_gap", cyc - t1, 19);
        chk("b2b_quotient", bus.quotient, 31);

        // done and outputs hold while ce=0, clear on next ce=1 edge.
        bus.ce = 1'b0;
        step(); step(); step();
        chk("ce0_done_hold", bus.done, 1);
        chk("ce0_quot_hold", bus.quotient, 31);
        bus.ce = 1'b1;
        step();
        chk("done_one_cycle", bus.done, 0);

        // Stall mid-CALC and an ignored start with new operands.
        bus.dividend = 18'd100;
        bus.divisor  = 5'd7;
        bus.start    = 1'b1;
        step();
        bus.start = 1'b0;
        edges = 0;
        for (int i = 0; i < 5; i++) begin step(); edges++; end
        bus.ce = 1'b0;
        hold_ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            edges++;
            if (bus.done !== 1'b0 || bus.ready !== 1'b0) hold_ok = 1'b0;
        end
        chk("stall_hold", hold_ok, 1);
        bus.ce       = 1'b1;
        bus.dividend = 18'd9;
        bus.divisor  = 5'd3;
        bus.start    = 1'b1;
        step();
        edges++;
        bus.start = 1'b0;
        lat = -1;
        for (int i = 0; i < 60; i++) begin
            if (bus.done === 1'b1) begin lat = edges; break; end
            step();
            edges++;
        end
        chk("stall_latency", lat, 23);
        chk("stall_quotient", bus.quotient, 14);
        chk("stall_remainder", bus.remainder, 2);
        extra_done = 0;
        for (int i = 0; i < 25; i++) begin
            step();
            if (bus.done === 1'b1) extra_done++;
        end
        chk("no_extra_done", extra_done, 0);

        // Reset in the middle of a division.
        bus.dividend = 18'd262143;
        bus.divisor  = 5'd31;
        bus.start    = 1'b1;
        step();
        bus.start = 1'b0;
        for (int i = 0; i < 8; i++) step();
        reset = 1'b1;
        #1;
        chk("midrst_quotient", bus.quotient, 0);
        chk("midrst_remainder", bus.remainder, 0);
        chk("midrst_ready", bus.ready, 1);
        chk("midrst_done", bus.done, 0);
        step();
        reset = 1'b0;
        extra_done = 0;
        hold_ok = 1'b1;
        for (int i = 0; i < 25; i++) begin
            step();
            if (bus.done === 1'b1) extra_done++;
            if (bus.ready !== 1'b1) hold_ok = 1'b0;
        end
        chk("midrst_no_done", extra_done, 0);
        chk("midrst_ready_stays", hold_ok, 1);
        run_div(18'd100, 5'd7, lat, rdy_ok);
        chk("post_rst_latency", lat, 18);
        chk("post_rst_quotient", bus.quotient, 14);
        chk("post_rst_remainder", bus.remainder, 2);

        // start together with reset is dropped.
        step();
        reset        = 1'b1;
        bus.dividend = 18'd5;
        bus.divisor  = 5'd1;
        bus.start    = 1'b1;
        step();
        reset     = 1'b0;
        bus.start = 1'b0;
        step();
        chk("rst_start_ready", bus.ready, 1);
        chk("rst_start_quotient", bus.quotient, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
